// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption core, one round per clock
`timescale 1ns/1ps
module aes128_encrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [127:0] rk_next;
    logic [127:0] round_out;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         accept;
    logic         last_round;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign last_round  = (round == 4'd10);
    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign cipher_text = state_reg;

    // Byte i of a 128-bit block lives at bits [127-8i -: 8]; i = row + 4*col.
    logic [7:0] sb [16];
    logic [7:0] sr [16];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = SBOX[state_reg[127-8*i -: 8]];
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sr[r+4*c] = sb[r + 4*((c + r) % 4)];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;
        assign a0 = sr[4*c];
        assign a1 = sr[4*c+1];
        assign a2 = sr[4*c+2];
        assign a3 = sr[4*c+3];
        assign m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        assign round_out[127-32*c -: 32] = last_round ? {a0, a1, a2, a3} : {m0, m1, m2, m3};
    end

    // Next round key: SubWord(RotWord(w3)) ^ rcon, then the cascaded XOR across the words.
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    assign {w0, w1, w2, w3} = rk_reg;
    assign t  = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_round) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= 128'h0;
            rk_reg    <= 128'h0;
            rcon      <= 8'h00;
            round     <= 4'd0;
        end else if (accept) begin
            state_reg <= plain_text ^ key;
            rk_reg    <= key;
            rcon      <= 8'h01;
            round     <= 4'd1;
        end else if (state == S_BUSY) begin
            state_reg <= round_out ^ rk_next;
            rk_reg    <= rk_next;
            rcon      <= xtime(rcon);
            round     <= round + 4'd1;
        end
    end

endmodule

// File: doc/aes128_encrypt_iter.md
# aes128_encrypt_iter

Iterative AES-128 encryption core (FIPS-197) that computes one round per clock with on-the-fly key expansion, behind valid/ready handshakes on both sides. It is the transmit-side counterpart of the combinational `AES_Decryption` block: ciphertext produced here decrypts to the original plaintext through that block with the same key. It is intended for the secure-link datapath, where a multi-cycle latency is acceptable in exchange for low area (a single round datapath).

## Interface
- No parameters; key size is fixed at 128 bits and the core always runs 10 rounds.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — `plain_text` and `key` are valid.
- `in_ready`  out  1  — core can accept a block (high only in IDLE).
- `plain_text`  in  128  — plaintext block; bits [127:120] are state byte s[0,0], with column-major byte order per FIPS-197.
- `key`  in  128  — cipher key, using the same byte order.
- `out_valid`  out  1  — `cipher_text` holds a completed result.
- `out_ready`  in  1  — downstream consumer accepts the result.
- `cipher_text`  out  128  — ciphertext, using the same byte order.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at an edge:
    - state_reg ← `plain_text` ^ `key` (round 0 AddRoundKey).
    - rk_reg ← `key`.
    - rcon ← 8'h01.
    - round ← 1.
    - Go to BUSY.
  - Inputs are sampled only at this edge; later changes to them are ignored.
- **BUSY**, one edge per round:
  - rk_next = KeyExpand(rk_reg, rcon), i.e. RotWord, SubWord and rcon XOR on word 3, then the cascaded XOR into words 0..3.
  - For round 1..9: state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next.
  - For round 10: MixColumns is skipped.
  - Each round also updates:
    - rk_reg ← rk_next.
    - rcon ← xtime(rcon), which gives the sequence 01,02,04,08,10,20,40,80,1b,36.
    - round ← round+1.
  - After the round-10 edge, go to DONE.
- **DONE**
  - `out_valid`=1 and `cipher_text`=state_reg; both stay stable until `out_valid`&&`out_ready`.
  - On that handshake edge, go to IDLE. `out_valid` drops and `in_ready` rises in the following cycle; there is no same-cycle bypass.
- The round counter is 4 bits and legal values are 1..10. The FSM never waits in BUSY.
- `in_valid` while the core is in BUSY or DONE has no effect. The upstream must hold the block until it sees `in_ready`.
- SubBytes uses 16 S-box instances and SubWord uses 4, all combinational lookups. There is no inverse S-box in this block.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `cipher_text`=128'h0, round=0, rcon=8'h00.
- Latency: if the input handshake occurs at edge E0, `out_valid` rises after edge E10 (10 cycles).
- Throughput, with `out_ready` held high:
  - E11 completes the output handshake.
  - `in_ready` is high after E11.
  - The next accept happens at E12.
  - The core therefore processes one block per 12 cycles.
- Backpressure: DONE persists for any number of cycles with `out_ready`=0, and the outputs stay constant.
- Reset mid-operation (in BUSY or DONE): the core returns to IDLE immediately. No `out_valid` is produced for the aborted block, and the first accept after release is processed normally.
- `out_ready` is a don't-care outside DONE.
- No combinational path exists from any input to any output: `in_ready`, `out_valid` and `cipher_text` are all register-driven.

## Test plan
- **FIPS-197 App. B:**
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, `out_ready`=1.
  - Required: `cipher_text` 3925841d02dc09fbdc118597196a0b32, with `out_valid` exactly 10 cycles after accept.
- **FIPS-197 App. C.1:**
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Also, all-zero pt with all-zero key → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- **Backpressure and input hold:**
  - Stimulus: hold `out_ready`=0 for 20 cycles in DONE, and change `plain_text`/`key` and pulse `in_valid` during BUSY.
  - Required: `cipher_text` stays 3925841d…0b32, `in_ready`=0 throughout, and no extra block is accepted.
- **Back-to-back:**
  - Stimulus: issue the App. B then App. C.1 vectors with `in_valid` held high and `out_ready`=1.
  - Required: second accept at E12 and both results correct, in order.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 asynchronously at round 5.
  - Required: `out_valid`=0, `in_ready`=1, `cipher_text`=0 immediately.
  - After release, the App. C.1 vector yields 69c4e0d8…c55a.
- **Round-trip:**
  - Stimulus: 200 random pt/key pairs, with each `cipher_text` fed to `AES_Decryption` under the same key.
  - Required: the recovered plaintext equals the original pt for every pair.
